// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU/PC+4 results immediately and holds for one load at a time.
// Optional WB_TRACE_EN macro adds a simulation trace of register writes and error events.
module writeback_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_src,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc4,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rd,
  output logic        writeEnable,
  output logic [31:0] data,
  output logic        stall,
  output logic        pend_valid,
  output logic [4:0]  pend_rd,
  output logic        err_misalign,
  output logic        err_funct3,
  output logic        err_timeout,
  output logic        state_dbg
);

  // Handshake: an instruction is taken on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, so a load in flight holds off everything behind it.

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [4:0]    lat_rd;
  logic [2:0]    lat_funct3;
  logic [1:0]    lat_addr_lo;

  logic          accept_load;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic          ld_mis, ld_bad_f3;

  logic          upd;
  logic [4:0]    wr_rd;
  logic [31:0]   wr_data;
  logic          set_mis, set_f3, set_to;

  assign accept_load = (state_q == IDLE) && in_valid && (in_src == 2'b01);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept_load) state_d = WAIT_MEM;
      WAIT_MEM: if (mem_rvalid || (cnt_q == CNT_LAST)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Load data extraction from the aligned word
  always_comb begin
    case (lat_addr_lo)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half   = lat_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data   = 32'h0;
    ld_mis    = 1'b0;
    ld_bad_f3 = 1'b0;
    case (lat_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001: begin
        ld_data = {{16{ld_half[15]}}, ld_half};
        ld_mis  = lat_addr_lo[0];
      end
      3'b101: begin
        ld_data = {16'h0, ld_half};
        ld_mis  = lat_addr_lo[0];
      end
      3'b010: begin
        ld_data = mem_rdata;
        ld_mis  = |lat_addr_lo;
      end
      default: ld_bad_f3 = 1'b1;
    endcase
  end

  // Output logic: write-port update and error events for this cycle
  always_comb begin
    upd     = 1'b0;
    wr_rd   = 5'd0;
    wr_data = 32'h0;
    set_mis = 1'b0;
    set_f3  = 1'b0;
    set_to  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && (in_src == 2'b00)) begin
          upd     = 1'b1;
          wr_rd   = in_rd;
          wr_data = in_alu_result;
        end else if (in_valid && (in_src == 2'b10)) begin
          upd     = 1'b1;
          wr_rd   = in_rd;
          wr_data = in_pc4;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          if (ld_bad_f3) begin
            set_f3 = 1'b1;
          end else if (ld_mis) begin
            set_mis = 1'b1;
          end else begin
            upd     = 1'b1;
            wr_rd   = lat_rd;
            wr_data = ld_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          set_to = 1'b1;
        end
      end
      default: ;
    endcase
    in_ready   = (state_q == IDLE);
    stall      = !in_ready;
    pend_valid = (state_q == WAIT_MEM);
    pend_rd    = pend_valid ? lat_rd : 5'd0;
    state_dbg  = state_q;
  end

  // Datapath registers; x0 never gets a write strobe but still shows the data
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      lat_rd       <= 5'd0;
      lat_funct3   <= 3'd0;
      lat_addr_lo  <= 2'd0;
      rd           <= 5'd0;
      writeEnable  <= 1'b0;
      data         <= 32'h0;
      err_misalign <= 1'b0;
      err_funct3   <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (accept_load) begin
        lat_rd      <= in_rd;
        lat_funct3  <= in_funct3;
        lat_addr_lo <= in_addr_lo;
      end
      if ((state_q == WAIT_MEM) && (state_d == WAIT_MEM)) cnt_q <= cnt_q + 1'b1;
      else                                                 cnt_q <= '0;
      writeEnable <= upd && (wr_rd != 5'd0);
      if (upd) begin
        rd   <= wr_rd;
        data <= wr_data;
      end
      err_misalign <= err_misalign | set_mis;
      err_funct3   <= err_funct3   | set_f3;
      err_timeout  <= err_timeout  | set_to;
    end
  end

`ifdef WB_TRACE_EN
  logic [2:0] err_prev;
  always_ff @(posedge clk) begin
    err_prev <= {err_misalign, err_funct3, err_timeout};
    if (writeEnable) $display("WB x%0d = %0d", rd, data);
    if (err_misalign && !err_prev[2]) $display("WB err_misalign");
    if (err_funct3   && !err_prev[1]) $display("WB err_funct3");
    if (err_timeout  && !err_prev[0]) $display("WB err_timeout");
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: table of single-cycle retirements, table of loads,
// and hand-written sequences for timeout, load hold-off and reset during a load.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = 5'd0;
  logic [1:0]  in_src = 2'b11;
  logic [31:0] in_alu_result = 32'h0;
  logic [31:0] in_pc4 = 32'h0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [1:0]  in_addr_lo = 2'd0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [4:0]  rd;
  logic        writeEnable;
  logic [31:0] data;
  logic        stall, pend_valid;
  logic [4:0]  pend_rd;
  logic        err_misalign, err_funct3, err_timeout, state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_unit #(.TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_src(in_src), .in_alu_result(in_alu_result), .in_pc4(in_pc4),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rd(rd), .writeEnable(writeEnable), .data(data),
    .stall(stall), .pend_valid(pend_valid), .pend_rd(pend_rd),
    .err_misalign(err_misalign), .err_funct3(err_funct3), .err_timeout(err_timeout),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } alu_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          delay;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_mis;
    logic        exp_f3;
  } ld_vec_t;

  alu_vec_t alu_tab[7];
  ld_vec_t  ld_tab[12];

  task automatic issue_load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] alo);
    in_valid   = 1'b1;
    in_src     = 2'b01;
    in_rd      = r;
    in_funct3  = f3;
    in_addr_lo = alo;
    tick();
    in_valid = 1'b0;
    in_src   = 2'b11;
  endtask

  task automatic run_load(input ld_vec_t v, input int idx);
    int stall_cnt;
    string s;
    do_reset();
    issue_load(v.rd, v.f3, v.alo);
    s = $sformatf("ld%0d", idx);
    check({s, "_pend_valid"}, pend_valid, 1'b1);
    check({s, "_pend_rd"}, pend_rd, v.rd);
    stall_cnt = 0;
    for (int i = 0; i < v.delay; i++) begin
      if (stall) stall_cnt++;
      tick();
    end
    if (stall) stall_cnt++;
    mem_rvalid = 1'b1;
    mem_rdata  = v.rdata;
    tick();
    mem_rvalid = 1'b0;
    check({s, "_stall_cycles"}, stall_cnt, v.delay + 1);
    check({s, "_we"}, writeEnable, v.exp_we);
    exp_q.push_back(v.exp_data);
    check({s, "_data"}, data, exp_q.pop_front());
    if (v.exp_we) check({s, "_rd"}, rd, v.rd);
    check({s, "_err_mis"}, err_misalign, v.exp_mis);
    check({s, "_err_f3"}, err_funct3, v.exp_f3);
    check({s, "_in_ready"}, in_ready, 1'b1);
    tick();
    check({s, "_we_after"}, writeEnable, 1'b0);
  endtask

  initial begin
    int we_seen;

    alu_tab[0] = '{1'b1, 5'd5,  2'b00, 32'd42,        32'd100,     1'b1, 5'd5,  32'd42};
    alu_tab[1] = '{1'b1, 5'd7,  2'b10, 32'd1,         32'h0000_1004, 1'b1, 5'd7, 32'h0000_1004};
    alu_tab[2] = '{1'b1, 5'd3,  2'b11, 32'd9,         32'd9,       1'b0, 5'd7,  32'h0000_1004};
    alu_tab[3] = '{1'b0, 5'd9,  2'b00, 32'd77,        32'd0,       1'b0, 5'd7,  32'h0000_1004};
    alu_tab[4] = '{1'b1, 5'd0,  2'b00, 32'hDEAD_BEEF, 32'd0,       1'b0, 5'd0,  32'hDEAD_BEEF};
    alu_tab[5] = '{1'b1, 5'd31, 2'b00, 32'hFFFF_FFFF, 32'd0,       1'b1, 5'd31, 32'hFFFF_FFFF};
    alu_tab[6] = '{1'b1, 5'd1,  2'b10, 32'd0,         32'd8,       1'b1, 5'd1,  32'd8};

    ld_tab[0]  = '{3'b000, 2'd2, 32'h0080_0000, 5'd4,  3, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0};
    ld_tab[1]  = '{3'b100, 2'd3, 32'hAB00_0000, 5'd4,  0, 1'b1, 32'h0000_00AB, 1'b0, 1'b0};
    ld_tab[2]  = '{3'b001, 2'd2, 32'h8001_0000, 5'd10, 1, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0};
    ld_tab[3]  = '{3'b101, 2'd2, 32'h8001_0000, 5'd11, 2, 1'b1, 32'h0000_8001, 1'b0, 1'b0};
    ld_tab[4]  = '{3'b101, 2'd0, 32'h1234_F00D, 5'd12, 0, 1'b1, 32'h0000_F00D, 1'b0, 1'b0};
    ld_tab[5]  = '{3'b010, 2'd0, 32'hCAFE_BABE, 5'd13, 1, 1'b1, 32'hCAFE_BABE, 1'b0, 1'b0};
    ld_tab[6]  = '{3'b000, 2'd1, 32'h0000_8000, 5'd14, 0, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0};
    ld_tab[7]  = '{3'b000, 2'd0, 32'h1234_5678, 5'd15, 0, 1'b1, 32'h0000_0078, 1'b0, 1'b0};
    ld_tab[8]  = '{3'b001, 2'd1, 32'h8001_0000, 5'd16, 0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    ld_tab[9]  = '{3'b010, 2'd2, 32'h1111_2222, 5'd17, 0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    ld_tab[10] = '{3'b011, 2'd0, 32'h1111_2222, 5'd18, 0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    ld_tab[11] = '{3'b010, 2'd0, 32'hCAFE_BABE, 5'd0,  0, 1'b0, 32'hCAFE_BABE, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    check("rst_rd", rd, 5'd0);
    check("rst_we", writeEnable, 1'b0);
    check("rst_data", data, 32'h0);
    check("rst_pend", {pend_valid, pend_rd}, 6'd0);
    check("rst_errs", {err_misalign, err_funct3, err_timeout}, 3'd0);
    check("rst_ready", in_ready, 1'b1);
    reset = 1'b0;

    // Back-to-back single-cycle retirements
    for (int i = 0; i < 7; i++) begin
      in_valid      = alu_tab[i].v;
      in_rd         = alu_tab[i].rd;
      in_src        = alu_tab[i].src;
      in_alu_result = alu_tab[i].alu;
      in_pc4        = alu_tab[i].pc4;
      tick();
      check($sformatf("alu%0d_we", i), writeEnable, alu_tab[i].exp_we);
      check($sformatf("alu%0d_rd", i), rd, alu_tab[i].exp_rd);
      check($sformatf("alu%0d_data", i), data, alu_tab[i].exp_data);
      check($sformatf("alu%0d_ready", i), in_ready, 1'b1);
    end
    in_valid = 1'b0;

    // Stray mem_rvalid while idle
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    check("idle_rvalid_we", writeEnable, 1'b0);
    check("idle_rvalid_data", data, 32'd8);
    check("idle_rvalid_ready", in_ready, 1'b1);

    for (int i = 0; i < 12; i++) run_load(ld_tab[i], i);

    // Instruction offered during a load is held off, load result wins
    do_reset();
    issue_load(5'd2, 3'b010, 2'd0);
    in_valid      = 1'b1;
    in_src        = 2'b00;
    in_rd         = 5'd9;
    in_alu_result = 32'd55;
    tick();
    check("hold_ready", in_ready, 1'b0);
    check("hold_stall", stall, 1'b1);
    check("hold_we", writeEnable, 1'b0);
    in_valid   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0011;
    tick();
    mem_rvalid = 1'b0;
    check("hold_ld_we", writeEnable, 1'b1);
    check("hold_ld_rd", rd, 5'd2);
    check("hold_ld_data", data, 32'h0000_0011);
    tick();
    check("hold_after_we", writeEnable, 1'b0);

    // Timeout boundary
    do_reset();
    issue_load(5'd8, 3'b010, 2'd0);
    we_seen = 0;
    for (int i = 0; i < 254; i++) begin
      if (writeEnable) we_seen++;
      tick();
    end
    check("to_stall_last", stall, 1'b1);
    check("to_err_early", err_timeout, 1'b0);
    tick();
    if (writeEnable) we_seen++;
    check("to_we_never", we_seen, 0);
    check("to_err", err_timeout, 1'b1);
    check("to_ready", in_ready, 1'b1);
    check("to_pend", pend_valid, 1'b0);

    // Reset mid-load with coincident mem_rvalid
    issue_load(5'd6, 3'b010, 2'd0);
    tick();
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0055;
    tick();
    check("rstld_we", writeEnable, 1'b0);
    check("rstld_rd", rd, 5'd0);
    check("rstld_data", data, 32'h0);
    check("rstld_pend", {pend_valid, pend_rd}, 6'd0);
    check("rstld_errs", {err_misalign, err_funct3, err_timeout}, 3'd0);
    check("rstld_ready", in_ready, 1'b1);
    reset      = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    check("rstld_after_we", writeEnable, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
